// File: rtl/dm_responder.sv
// Data-memory responder: processor read/write port plus a host load/dump port,
// with LOAD -> RUN -> DUMP ownership sequencing of a single RAM.
module dm_responder #(
  parameter int DW    = 12,
  parameter int AW    = 12,
  parameter int DEPTH = 1024,
  parameter int BUSW  = 17
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   ar_in,
  input  logic [BUSW-1:0] bus_in,
  input  logic            dm_en,
  input  logic            end_process,
  output logic [DW-1:0]   dm_out,
  output logic            cpu_run,
  input  logic            host_go,
  input  logic            host_req,
  input  logic            host_we,
  input  logic [AW-1:0]   host_addr,
  input  logic [DW-1:0]   host_wdata,
  output logic [DW-1:0]   host_rdata,
  output logic            host_ack,
  output logic            host_err,
  output logic            oob,
  output logic [AW-1:0]   wr_count
);

  localparam int IW = $clog2(DEPTH);

  typedef enum logic [1:0] {ST_LOAD, ST_RUN, ST_DUMP} state_t;

  state_t        state, state_nxt;
  logic [DW-1:0] mem [DEPTH];

  logic host_accept, host_access, host_wr, proc_wr, enter_load;
  logic unused_bus_hi;

  function automatic logic in_range(input logic [AW-1:0] a);
    return 32'(a) < 32'(DEPTH);
  endfunction

  function automatic logic [AW-1:0] sat_inc(input logic [AW-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  assign unused_bus_hi = ^bus_in[BUSW-1:DW];

  // Outstanding ack/err blocks a new acceptance, giving the 2-cycle cadence.
  assign host_accept = host_req & ~host_ack & ~host_err;
  assign host_access = host_accept & (state != ST_RUN);
  assign host_wr     = host_access & host_we;
  assign proc_wr     = (state == ST_RUN) & dm_en;
  assign enter_load  = (state == ST_DUMP) & (state_nxt == ST_LOAD);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_LOAD: if (host_go)     state_nxt = ST_RUN;
      ST_RUN:  if (end_process) state_nxt = ST_DUMP;
      ST_DUMP: if (host_go)     state_nxt = ST_LOAD;
      default:                  state_nxt = ST_LOAD;
    endcase
  end

  // RAM: writers are phase-exclusive; writes are suppressed while reset is held.
  always_ff @(posedge clk) begin
    if (rst_n && proc_wr && in_range(ar_in))
      mem[ar_in[IW-1:0]] <= bus_in[DW-1:0];
    else if (rst_n && host_wr && in_range(host_addr))
      mem[host_addr[IW-1:0]] <= host_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_LOAD;
      cpu_run    <= 1'b0;
      dm_out     <= '0;
      host_rdata <= '0;
      host_ack   <= 1'b0;
      host_err   <= 1'b0;
      oob        <= 1'b0;
      wr_count   <= '0;
    end else begin
      state    <= state_nxt;
      cpu_run  <= (state_nxt == ST_RUN);
      dm_out   <= in_range(ar_in) ? mem[ar_in[IW-1:0]] : '0;
      host_ack <= host_access;
      host_err <= host_accept & (state == ST_RUN);
      if (host_access && !host_we)
        host_rdata <= in_range(host_addr) ? mem[host_addr[IW-1:0]] : '0;
      if (enter_load) begin
        oob      <= 1'b0;
        wr_count <= '0;
      end else begin
        if ((proc_wr && !in_range(ar_in)) || (host_access && !in_range(host_addr)))
          oob <= 1'b1;
        if (proc_wr)
          wr_count <= sat_inc(wr_count);
      end
    end
  end

endmodule

// File: tb/tb_dm_responder.sv
// Bench for dm_responder: directed vector table, random traffic against a
// phase/array reference model, wr_count saturation and mid-run reset.
module tb_dm_responder;
  localparam int DW = 12, AW = 12, DEPTH = 1024, BUSW = 17;

  logic clk = 1'b0;
  logic rst_n;
  logic [AW-1:0] ar_in, host_addr;
  logic [BUSW-1:0] bus_in;
  logic dm_en, end_process, host_go, host_req, host_we;
  logic [DW-1:0] host_wdata, dm_out, host_rdata;
  logic cpu_run, host_ack, host_err, oob;
  logic [AW-1:0] wr_count;

  always #5 clk = ~clk;

  dm_responder #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .BUSW(BUSW)) dut (
    .clk(clk), .rst_n(rst_n), .ar_in(ar_in), .bus_in(bus_in), .dm_en(dm_en),
    .end_process(end_process), .dm_out(dm_out), .cpu_run(cpu_run),
    .host_go(host_go), .host_req(host_req), .host_we(host_we),
    .host_addr(host_addr), .host_wdata(host_wdata), .host_rdata(host_rdata),
    .host_ack(host_ack), .host_err(host_err), .oob(oob), .wr_count(wr_count)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit chk_dm = 1'b1;

  typedef struct {
    logic req, we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
    logic go, en;
    logic [AW-1:0] ar;
    logic [BUSW-1:0] bus;
    logic endp;
  } in_t;

  typedef struct {
    in_t i;
    logic ack, err, run, o;
    logic [DW-1:0] rd, dm;
    logic [AW-1:0] wr;
  } vec_t;

  vec_t tbl[$];

  // Reference model: phase 0=LOAD 1=RUN 2=DUMP, memory as a plain array.
  int ph;
  logic [DW-1:0] mm [DEPTH];
  logic [DW-1:0] m_dm, m_rd;
  logic m_ack, m_err, m_oob, m_run;
  int m_wr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic in_t mk(logic req, logic we, logic [AW-1:0] addr, logic [DW-1:0] wd,
                             logic go, logic en, logic [AW-1:0] ar, logic [BUSW-1:0] bus,
                             logic endp);
    in_t v;
    v.req = req; v.we = we; v.addr = addr; v.wd = wd; v.go = go;
    v.en = en; v.ar = ar; v.bus = bus; v.endp = endp;
    return v;
  endfunction

  task automatic add(input in_t v, input logic ack, input logic err, input logic run,
                     input logic o, input logic [DW-1:0] rd, input logic [DW-1:0] dm,
                     input logic [AW-1:0] wr);
    vec_t e;
    e.i = v; e.ack = ack; e.err = err; e.run = run; e.o = o;
    e.rd = rd; e.dm = dm; e.wr = wr;
    tbl.push_back(e);
  endtask

  task automatic model_reset();
    ph = 0; m_dm = '0; m_rd = '0; m_ack = 0; m_err = 0; m_oob = 0; m_run = 0; m_wr = 0;
  endtask

  task automatic model_step(input in_t v);
    logic acc;
    int nph;
    acc = v.req && !m_ack && !m_err;
    m_dm = (int'(v.ar) < DEPTH) ? mm[int'(v.ar)] : '0;
    if (acc && ph != 1 && !v.we)
      m_rd = (int'(v.addr) < DEPTH) ? mm[int'(v.addr)] : '0;
    nph = ph;
    if (ph == 0 && v.go) nph = 1;
    else if (ph == 1 && v.endp) nph = 2;
    else if (ph == 2 && v.go) nph = 0;
    if (ph == 1 && v.en) begin
      if (int'(v.ar) < DEPTH) mm[int'(v.ar)] = v.bus[DW-1:0];
      else m_oob = 1;
      if (m_wr < (1 << AW) - 1) m_wr++;
    end
    if (acc && ph != 1) begin
      if (int'(v.addr) < DEPTH) begin
        if (v.we) mm[int'(v.addr)] = v.wd;
      end else m_oob = 1;
    end
    if (ph == 2 && nph == 0) begin
      m_oob = 0;
      m_wr = 0;
    end
    m_ack = acc && ph != 1;
    m_err = acc && ph == 1;
    ph = nph;
    m_run = (ph == 1);
  endtask

  task automatic drive(input in_t v);
    host_req = v.req; host_we = v.we; host_addr = v.addr; host_wdata = v.wd;
    host_go = v.go; dm_en = v.en; ar_in = v.ar; bus_in = v.bus; end_process = v.endp;
  endtask

  task automatic cycle(input in_t v);
    @(negedge clk);
    drive(v);
    model_step(v);
    @(posedge clk);
    #1;
    cyc++;
    if (chk_dm) chk("dm_out", 32'(dm_out), 32'(m_dm));
    chk("host_rdata", 32'(host_rdata), 32'(m_rd));
    chk("host_ack", 32'(host_ack), 32'(m_ack));
    chk("host_err", 32'(host_err), 32'(m_err));
    chk("oob", 32'(oob), 32'(m_oob));
    chk("wr_count", 32'(wr_count), 32'(m_wr));
    chk("cpu_run", 32'(cpu_run), 32'(m_run));
  endtask

  task automatic idle();
    cycle(mk(0, 0, '0, '0, 0, 0, '0, '0, 0));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_dm_out"}, 32'(dm_out), 0);
    chk({tag, "_rdata"}, 32'(host_rdata), 0);
    chk({tag, "_ack"}, 32'(host_ack), 0);
    chk({tag, "_err"}, 32'(host_err), 0);
    chk({tag, "_oob"}, 32'(oob), 0);
    chk({tag, "_wr"}, 32'(wr_count), 0);
    chk({tag, "_run"}, 32'(cpu_run), 0);
  endtask

  task automatic goto_phase(input int target);
    for (int k = 0; k < 6 && ph != target; k++)
      cycle(mk(0, 0, '0, '0, ph != 1, 0, '0, '0, ph == 1));
    chk("goto_phase", 32'(ph), 32'(target));
  endtask

  initial begin
    in_t v;
    rst_n = 1'b0;
    drive(mk(0, 0, '0, '0, 0, 0, '0, '0, 0));
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Fill the RAM with a known pattern so every read has a defined answer.
    chk_dm = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      cycle(mk(1, 1, AW'(i), DW'(i * 5 + 1), 0, 0, '0, '0, 0));
      idle();
    end
    chk_dm = 1'b1;

    // Directed sequence; mem[3]=0x010, mem[0]=0x001 from the fill pattern.
    add(mk(1, 1, 12'h003, 12'h0A5, 0, 0, 12'h003, '0, 0),       1, 0, 0, 0, 12'h000, 12'h010, 0);
    add(mk(0, 0, 12'h000, 12'h000, 0, 0, 12'h003, '0, 0),       0, 0, 0, 0, 12'h000, 12'h0A5, 0);
    add(mk(1, 0, 12'h003, 12'h000, 0, 0, 12'h003, '0, 0),       1, 0, 0, 0, 12'h0A5, 12'h0A5, 0);
    add(mk(0, 0, 12'h000, 12'h000, 1, 0, 12'h003, '0, 0),       0, 0, 1, 0, 12'h0A5, 12'h0A5, 0);
    add(mk(0, 0, 12'h000, 12'h000, 0, 1, 12'h003, 17'h10F3C, 0), 0, 0, 1, 0, 12'h0A5, 12'h0A5, 1);
    add(mk(0, 0, 12'h000, 12'h000, 0, 0, 12'h003, '0, 0),       0, 0, 1, 0, 12'h0A5, 12'hF3C, 1);
    add(mk(1, 1, 12'h003, 12'h111, 1, 0, 12'h003, '0, 0),       0, 1, 1, 0, 12'h0A5, 12'hF3C, 1);
    add(mk(1, 1, 12'h003, 12'h111, 0, 0, 12'h003, '0, 0),       0, 0, 1, 0, 12'h0A5, 12'hF3C, 1);
    add(mk(1, 1, 12'h003, 12'h111, 0, 0, 12'h003, '0, 0),       0, 1, 1, 0, 12'h0A5, 12'hF3C, 1);
    add(mk(0, 0, 12'h000, 12'h000, 0, 0, 12'h003, '0, 0),       0, 0, 1, 0, 12'h0A5, 12'hF3C, 1);
    add(mk(0, 0, 12'h000, 12'h000, 0, 0, 12'h003, '0, 1),       0, 0, 0, 0, 12'h0A5, 12'hF3C, 1);
    add(mk(0, 0, 12'h000, 12'h000, 0, 1, 12'h003, 17'h00777, 0), 0, 0, 0, 0, 12'h0A5, 12'hF3C, 1);
    add(mk(1, 0, 12'h003, 12'h000, 0, 0, 12'h003, '0, 0),       1, 0, 0, 0, 12'hF3C, 12'hF3C, 1);
    add(mk(0, 0, 12'h000, 12'h000, 1, 0, 12'h003, '0, 0),       0, 0, 0, 0, 12'hF3C, 12'hF3C, 0);
    add(mk(0, 0, 12'h000, 12'h000, 1, 0, 12'h003, '0, 0),       0, 0, 1, 0, 12'hF3C, 12'hF3C, 0);
    add(mk(0, 0, 12'h000, 12'h000, 0, 1, 12'h400, 17'h00123, 0), 0, 0, 1, 1, 12'hF3C, 12'h000, 1);
    add(mk(0, 0, 12'h000, 12'h000, 0, 0, 12'h000, '0, 0),       0, 0, 1, 1, 12'hF3C, 12'h001, 1);
    add(mk(0, 0, 12'h000, 12'h000, 0, 0, 12'h000, '0, 1),       0, 0, 0, 1, 12'hF3C, 12'h001, 1);
    add(mk(1, 0, 12'h7FF, 12'h000, 0, 0, 12'h000, '0, 0),       1, 0, 0, 1, 12'h000, 12'h001, 1);
    add(mk(0, 0, 12'h000, 12'h000, 1, 0, 12'h000, '0, 0),       0, 0, 0, 0, 12'h000, 12'h001, 0);

    foreach (tbl[n]) begin
      cycle(tbl[n].i);
      chk($sformatf("tbl%0d_ack", n), 32'(host_ack), 32'(tbl[n].ack));
      chk($sformatf("tbl%0d_err", n), 32'(host_err), 32'(tbl[n].err));
      chk($sformatf("tbl%0d_run", n), 32'(cpu_run), 32'(tbl[n].run));
      chk($sformatf("tbl%0d_oob", n), 32'(oob), 32'(tbl[n].o));
      chk($sformatf("tbl%0d_rdata", n), 32'(host_rdata), 32'(tbl[n].rd));
      chk($sformatf("tbl%0d_dm", n), 32'(dm_out), 32'(tbl[n].dm));
      chk($sformatf("tbl%0d_wr", n), 32'(wr_count), 32'(tbl[n].wr));
    end

    // Random traffic across all phases.
    for (int n = 0; n < 3000; n++) begin
      v.req  = 1'($urandom_range(0, 1));
      v.we   = 1'($urandom_range(0, 1));
      v.addr = ($urandom_range(0, 7) == 0) ? AW'($urandom_range(1024, 4095)) : AW'($urandom_range(0, 1023));
      v.ar   = ($urandom_range(0, 7) == 0) ? AW'($urandom_range(1024, 4095)) : AW'($urandom_range(0, 1023));
      v.wd   = DW'($urandom);
      v.bus  = BUSW'($urandom);
      v.en   = 1'($urandom_range(0, 1));
      v.go   = ($urandom_range(0, 15) == 0);
      v.endp = ($urandom_range(0, 15) == 0);
      cycle(v);
    end

    // wr_count saturation over a long run.
    goto_phase(1);
    for (int n = 0; n < 4100; n++)
      cycle(mk(0, 0, '0, '0, 0, 1, AW'($urandom_range(0, 1023)), BUSW'($urandom), 0));
    chk("wr_sat", 32'(wr_count), 32'((1 << AW) - 1));
    goto_phase(0);

    // Reset asserted in RUN during a processor write.
    cycle(mk(1, 1, 12'h003, 12'h3C3, 0, 0, 12'h000, '0, 0));
    idle();
    cycle(mk(0, 0, '0, '0, 1, 0, 12'h003, '0, 0));
    chk("pre_rst_run", 32'(cpu_run), 1);
    @(negedge clk);
    drive(mk(1, 0, 12'h003, '0, 0, 1, 12'h003, 17'h00FFF, 0));
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("midrst");
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    drive(mk(0, 0, '0, '0, 0, 0, '0, '0, 0));
    cycle(mk(1, 0, 12'h003, '0, 0, 0, 12'h003, '0, 0));
    chk("post_rst_rdata", 32'(host_rdata), 32'h3C3);
    chk("post_rst_ack", 32'(host_ack), 1);
    chk("post_rst_dm", 32'(dm_out), 32'h3C3);
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout cycle=%0d actual=running required=finished", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dm_responder.md
Name: dm_responder

Overview:
- Data-memory responder on the far side of the processor's data-memory interface.
- Serves the processor's address (`ar_out`), write data (`bus_out`) and write strobe (`dm_en`), and returns registered read data on `dm_out`.
- Adds a host load/dump port and a three-phase ownership FSM:
  - host loads operands;
  - processor runs;
  - host reads results back after `end_process`.

Parameters:
- DW, 12: data word width (matches processor register width).
- AW, 12: address width presented by processor and host.
- DEPTH, 1024: implemented words; addresses >= DEPTH are out of range.
- BUSW, 17: processor bus width; only bits [DW-1:0] are stored.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ar_in  in  AW  processor address (AR).
- bus_in  in  BUSW  processor bus; write data = bus_in[DW-1:0].
- dm_en  in  1  processor write strobe (already registered by processor).
- end_process  in  1  processor completion level.
- dm_out  out  DW  registered read data to processor.
- cpu_run  out  1  high while the processor owns memory; gates processor start.
- host_go  in  1  one-cycle phase-advance pulse from host.
- host_req  in  1  host access request (level).
- host_we  in  1  1 = write, 0 = read; sampled with host_req.
- host_addr  in  AW  host address.
- host_wdata  in  DW  host write data.
- host_rdata  out  DW  host read data, valid while host_ack = 1.
- host_ack  out  1  one-cycle completion pulse.
- host_err  out  1  one-cycle pulse when a request is rejected.
- oob  out  1  sticky out-of-range flag; cleared on entry to LOAD.
- wr_count  out  AW  count of processor writes in the current RUN, saturating.

Behaviour:
- Reset (async, rst_n = 0):
  - state = LOAD;
  - dm_out, host_rdata, host_ack, host_err, oob, wr_count, cpu_run all 0;
  - RAM contents are not reset.
- FSM, all transitions on clk:
  - LOAD: host read/write allowed; host_go -> RUN.
  - RUN: cpu_run = 1; processor owns the RAM.
    - end_process = 1 -> DUMP; takes priority over host_go.
    - host_go is ignored.
  - DUMP: host read/write allowed; processor writes are ignored.
    - host_go -> LOAD; clears oob and wr_count.
- cpu_run is registered: it is 1 in the cycle after LOAD -> RUN and 0 in the cycle after RUN -> DUMP.
- Processor read: dm_out <= mem[ar_in] every cycle in every state.
  - Latency 1 cycle.
  - Out-of-range address returns 0.
- Processor write: in RUN with dm_en = 1, mem[ar_in] <= bus_in[DW-1:0].
  - Same-cycle read of the same address returns the old data.
  - wr_count increments and saturates at 2^AW-1.
  - An out-of-range write is dropped and sets oob; wr_count still increments.
- Host handshake:
  - A request is accepted in cycle N when host_req = 1 and host_ack = 0 in cycle N.
  - host_ack pulses in cycle N+1; a read returns host_rdata = mem[host_addr as sampled in N].
  - A held host_req yields one transaction every 2 cycles.
  - host_rdata holds its value until the next accepted read.
- Host write: mem[host_addr] <= host_wdata in cycle N.
  - An out-of-range write is dropped, sets oob, and is still acked.
  - An out-of-range read returns 0, is acked, and sets oob.
- Host request in RUN: no RAM access, no host_ack; host_err pulses in cycle N+1, with the same 2-cycle cadence as an accepted request.
- Simultaneous events:
  - host_go with host_req in LOAD or DUMP: the access completes in the old phase, then the state changes.
  - end_process already high on RUN entry: DUMP next cycle (zero-length run).
- Single-port RAM semantics: the processor and the host never write in the same phase, so no write collision exists.
- Reset mid-transaction aborts it: no ack, state = LOAD, RAM retains its contents.

Test Plan:
- Load then read back: in LOAD, host writes 0x0A5 to addr 3 -> host_ack pulses 1 cycle later. Host reads addr 3 -> host_rdata = 0x0A5 with host_ack.
- Processor run:
  - host_go -> cpu_run = 1 next cycle.
  - dm_en = 1, ar_in = 3, bus_in = 0x1_0F3C -> mem[3] = 0xF3C, wr_count = 1.
  - ar_in = 3 with dm_en = 0 -> dm_out = 0xF3C one cycle later.
- Rejection in RUN: host_req = 1 -> host_err pulses, host_ack stays 0, mem unchanged.
- Completion: end_process = 1 -> DUMP, cycle after cpu_run = 0. dm_en = 1 is ignored. Host reads addr 3 -> 0xF3C.
- Out of range: processor write to addr 0x400 (DEPTH = 1024) -> oob = 1, write dropped. Host read of 0x7FF -> host_rdata = 0, host_ack pulses. host_go back to LOAD -> oob = 0, wr_count = 0.
- Reset mid-operation: assert rst_n = 0 in RUN during a write -> outputs 0 immediately, state = LOAD. Previously loaded mem[3] is still readable after reset release.
